// File: rtl/lcd_responder.sv
// HD44780-style write-side bus responder: synchronizes the LCD bus, decodes strobes,
// executes write instructions and mirrors the 2x16 character RAM for readback.
module lcd_responder #(
    parameter int unsigned MIN_EN_HIGH = 2,
    parameter logic [7:0]  CLEAR_FILL  = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       EN,
    input  logic       RW,
    input  logic       RS,
    input  logic [7:0] data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [4:0] cursor,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       entry_inc,
    output logic       busy,
    output logic       cmd_valid,
    output logic [7:0] last_byte,
    output logic       last_rs,
    output logic       addr_err,
    output logic       rw_err,
    output logic       overrun
);

    localparam int unsigned CW = $clog2(MIN_EN_HIGH + 1);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t        state, state_nxt;
    logic [4:0]    clr_addr, clr_nxt;
    logic          en_s1, en_s2, rw_s1, rw_s2, rs_s1, rs_s2;
    logic [7:0]    data_s1, data_s2;
    logic          bus_rw, bus_rs;
    logic [7:0]    bus_data;
    logic [CW-1:0] run_cnt;
    logic          strobe;

    logic [4:0]    cursor_nxt;
    logic          display_nxt, cursor_on_nxt, blink_nxt, two_line_nxt, entry_nxt;
    logic          valid_nxt, aerr_nxt, rwerr_nxt, ovr_nxt;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [7:0]    wr_data;
    logic [4:0]    step;

    logic [7:0]    mem [32];

    // Bus fields are captured during every synchronized EN-high cycle, so the strobe
    // sees the values from the final high cycle once EN has dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_s1    <= 1'b0;
            en_s2    <= 1'b0;
            rw_s1    <= 1'b0;
            rw_s2    <= 1'b0;
            rs_s1    <= 1'b0;
            rs_s2    <= 1'b0;
            data_s1  <= '0;
            data_s2  <= '0;
            bus_rw   <= 1'b0;
            bus_rs   <= 1'b0;
            bus_data <= '0;
            run_cnt  <= '0;
        end else begin
            en_s1   <= EN;
            en_s2   <= en_s1;
            rw_s1   <= RW;
            rw_s2   <= rw_s1;
            rs_s1   <= RS;
            rs_s2   <= rs_s1;
            data_s1 <= data;
            data_s2 <= data_s1;
            if (en_s2) begin
                bus_rw   <= rw_s2;
                bus_rs   <= rs_s2;
                bus_data <= data_s2;
                if (run_cnt != CW'(MIN_EN_HIGH)) run_cnt <= run_cnt + 1'b1;
            end else begin
                run_cnt <= '0;
            end
        end
    end

    // run_cnt still holds the high-time count during the first low cycle.
    assign strobe = !en_s2 && (run_cnt == CW'(MIN_EN_HIGH));
    assign step   = entry_inc ? 5'd1 : 5'd31;

    always_comb begin
        state_nxt     = state;
        clr_nxt       = clr_addr;
        cursor_nxt    = cursor;
        display_nxt   = display_on;
        cursor_on_nxt = cursor_on;
        blink_nxt     = blink_on;
        two_line_nxt  = two_line;
        entry_nxt     = entry_inc;
        valid_nxt     = 1'b0;
        aerr_nxt      = 1'b0;
        rwerr_nxt     = 1'b0;
        ovr_nxt       = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = clr_addr;
        wr_data       = CLEAR_FILL;

        if (state == S_CLEAR) begin
            wr_en   = 1'b1;
            clr_nxt = clr_addr + 5'd1;
            if (clr_addr == 5'd31) state_nxt = S_IDLE;
        end

        if (strobe) begin
            if (bus_rw) begin
                rwerr_nxt = 1'b1;
            end else if (state == S_CLEAR) begin
                ovr_nxt = 1'b1;
            end else if (bus_rs) begin
                valid_nxt  = 1'b1;
                wr_en      = 1'b1;
                wr_addr    = cursor;
                wr_data    = bus_data;
                cursor_nxt = cursor + step;
            end else begin
                valid_nxt = 1'b1;
                casez (bus_data)
                    8'b1???????: begin
                        if (bus_data[6:4] == 3'b000)      cursor_nxt = {1'b0, bus_data[3:0]};
                        else if (bus_data[6:4] == 3'b100) cursor_nxt = {1'b1, bus_data[3:0]};
                        else begin
                            valid_nxt = 1'b0;
                            aerr_nxt  = 1'b1;
                        end
                    end
                    8'b01??????: ;
                    8'b001?????: two_line_nxt = bus_data[3];
                    8'b0001????: begin
                        if (!bus_data[3]) cursor_nxt = bus_data[2] ? cursor + 5'd1 : cursor - 5'd1;
                    end
                    8'b00001???: begin
                        display_nxt   = bus_data[2];
                        cursor_on_nxt = bus_data[1];
                        blink_nxt     = bus_data[0];
                    end
                    8'b000001??: entry_nxt = bus_data[1];
                    8'b0000001?: cursor_nxt = '0;
                    8'b00000001: begin
                        state_nxt  = S_CLEAR;
                        clr_nxt    = '0;
                        cursor_nxt = '0;
                        entry_nxt  = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_CLEAR;
            clr_addr   <= '0;
            cursor     <= '0;
            display_on <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            two_line   <= 1'b0;
            entry_inc  <= 1'b1;
            cmd_valid  <= 1'b0;
            addr_err   <= 1'b0;
            rw_err     <= 1'b0;
            overrun    <= 1'b0;
            last_byte  <= '0;
            last_rs    <= 1'b0;
            rd_char    <= '0;
        end else begin
            state      <= state_nxt;
            clr_addr   <= clr_nxt;
            cursor     <= cursor_nxt;
            display_on <= display_nxt;
            cursor_on  <= cursor_on_nxt;
            blink_on   <= blink_nxt;
            two_line   <= two_line_nxt;
            entry_inc  <= entry_nxt;
            cmd_valid  <= valid_nxt;
            addr_err   <= aerr_nxt;
            rw_err     <= rwerr_nxt;
            overrun    <= ovr_nxt;
            if (valid_nxt) begin
                last_byte <= bus_data;
                last_rs   <= bus_rs;
            end
            rd_char    <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign busy = (state == S_CLEAR);

endmodule
